// File: rtl/wb_regfile_stage.sv
// Write-back stage: selects the write-back value, updates the register file and feeds a one-cycle forwarding register.
// Optional WB_RETIRE_CNT_EN adds a 32-bit retire_count output counting committed register writes.
module wb_regfile_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] F_in,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             RW,
  input  logic [AW-1:0]    DA,
  input  logic             N_xor_V,
  input  logic [1:0]       MD,
  input  logic [AW-1:0]    AA,
  input  logic [AW-1:0]    BA,
  output logic [WIDTH-1:0] A_data,
  output logic [WIDTH-1:0] B_data,
  output logic [WIDTH-1:0] D_data,
  output logic             fwd_valid,
  output logic [AW-1:0]    fwd_DA,
  output logic [WIDTH-1:0] fwd_D
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]      retire_count
`endif
);

  localparam int NREGS = 2 ** AW;

  logic [WIDTH-1:0] regs [NREGS];
  logic             wr_en;

  assign wr_en = RW && (DA != '0) && !reset;

  always_comb begin
    D_data = F_in;
    case (MD)
      2'b01:   D_data = mem_data;
      2'b10:   D_data = {{(WIDTH-1){1'b0}}, N_xor_V};
      default: D_data = F_in;
    endcase
  end

  // Register 0 is hardwired to zero; a write in flight is bypassed to matching read ports.
  always_comb begin
    A_data = regs[AA];
    if (AA == '0)
      A_data = '0;
    else if (wr_en && (AA == DA))
      A_data = D_data;
  end

  always_comb begin
    B_data = regs[BA];
    if (BA == '0)
      B_data = '0;
    else if (wr_en && (BA == DA))
      B_data = D_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[DA] <= D_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid <= 1'b0;
      fwd_DA    <= '0;
      fwd_D     <= '0;
    end else begin
      fwd_valid <= RW && (DA != '0);
      fwd_DA    <= DA;
      fwd_D     <= D_data;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      retire_count <= '0;
    else if (wr_en)
      retire_count <= retire_count + 32'd1;
  end
`endif

endmodule

// File: doc/wb_regfile_stage.md
WB_REGFILE_STAGE -- requirements
Module: wb_regfile_stage

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width.
REQ-002 The block SHALL have parameter AW, default 5, register address width (2^AW registers).
REQ-003 The block SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-004 The block SHALL have these data and control inputs:
- F_in  in  WIDTH  ALU result from execute.
- mem_data  in  WIDTH  data-memory read value.
- RW  in  1  register-write enable.
- DA  in  AW  destination register.
- N_xor_V  in  1  set-less-than flag.
- MD  in  2  write-back source select.
- AA  in  AW  read port A address.
- BA  in  AW  read port B address.
REQ-005 The block SHALL have these outputs:
- A_data  out  WIDTH  port A read data.
- B_data  out  WIDTH  port B read data.
- D_data  out  WIDTH  selected write-back value (combinational).
- fwd_valid  out  1  registered write-back valid.
- fwd_DA  out  AW  registered write-back address.
- fwd_D  out  WIDTH  registered write-back data.

Function
REQ-006 D_data SHALL be selected by MD:
- 00: F_in.
- 01: mem_data.
- 10: zero-extended N_xor_V (bit 0 = N_xor_V, upper bits 0).
- 11: F_in (reserved).
REQ-007 The register file SHALL hold 2^AW registers of WIDTH bits, written on the rising clk edge.
REQ-008 A write SHALL occur iff RW=1, DA!=0 and reset=0; register DA takes D_data at that edge.
REQ-009 Register 0 SHALL always read 0; writes to it are discarded.
REQ-010 A_data and B_data SHALL be combinational reads of AA and BA.
REQ-011 Write-through bypass: if RW=1, DA!=0, reset=0 and AA==DA, A_data SHALL equal the current D_data; the same rule applies to BA/B_data.
REQ-012 With both ports addressing the same register, both SHALL return identical values, including the bypassed value.
REQ-013 At each rising edge, fwd_valid SHALL load (RW && DA!=0), fwd_DA SHALL load DA and fwd_D SHALL load D_data, giving one-cycle latency for the forwarding unit.
REQ-014 Back-to-back writes to the same DA SHALL leave the last-written value; no write is lost or merged.
REQ-015 X or unknown MD values are not required to be handled; the 11 encoding SHALL be deterministic per REQ-006.

Reset
REQ-016 While reset=1 at a rising edge, all registers SHALL be cleared to 0.
REQ-017 While reset=1 at a rising edge, fwd_valid, fwd_DA and fwd_D SHALL be cleared to 0.
REQ-018 A write presented during a reset cycle SHALL be suppressed, and bypass SHALL be disabled while reset=1.
REQ-019 A reset asserted between two writes SHALL leave no trace of the earlier write.

Configuration
REQ-020 Macro WB_RETIRE_CNT_EN, when defined, SHALL add output retire_count (out, 32 bits), which increments by 1 at each rising edge where a write per REQ-008 occurs, wraps from 0xFFFFFFFF to 0, and resets to 0.
REQ-021 Without WB_RETIRE_CNT_EN, the retire_count port and its counter SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-022 After reset, read AA=5, BA=31 -> A_data=0, B_data=0, fwd_valid=0.
REQ-023 Write-source select:
- RW=1, DA=3, MD=00, F_in=0x12345678, then read AA=3 next cycle -> A_data=0x12345678, fwd_valid=1, fwd_DA=3, fwd_D=0x12345678.
- RW=1, DA=4, MD=10, N_xor_V=1 -> register 4 = 0x00000001.
- RW=1, DA=6, MD=01, mem_data=0xDEADBEEF -> register 6 = 0xDEADBEEF.
REQ-024 Bypass: RW=1, DA=7, MD=00, F_in=0xA5A5A5A5, AA=BA=7 in the same cycle -> A_data=B_data=0xA5A5A5A5 before the edge.
REQ-025 R0 protection: RW=1, DA=0, F_in=0xFFFFFFFF -> A_data(AA=0)=0, fwd_valid=0, no bypass.
REQ-026 Reset behaviour:
- Write DA=9=0x55, then reset=1 for one cycle together with RW=1, DA=9, F_in=0x66 -> register 9 reads 0.
- With WB_RETIRE_CNT_EN defined, the same sequence -> retire_count=0 after reset, 1 after a subsequent valid write.
